yin_diff_engine: RTL

YIN_DIFF_ENGINE -- requirements
Module: yin_diff_engine

---
 rtl/yin_diff_engine_pkg.sv | 19 +
 rtl/yin_diff_engine_square_diff.sv | 24 ++
 rtl/yin_diff_engine.sv | 134 +++++++++++++
 3 files changed

// File: rtl/yin_diff_engine_pkg.sv
// Shared constants and FSM encoding for the YIN difference-function engine.
package yin_diff_engine_pkg;

    localparam int DATA_WIDTH_BITS      = 16;
    localparam int BUFFER_SIZE_BITS     = 10;
    localparam int DEF_WINDOW_SIZE_BITS = 8;
    localparam int DEF_TAU_MIN          = 0;
    localparam int DEF_TAU_MAX          = 255;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH_A = 3'd1,
        ST_FETCH_B = 3'd2,
        ST_ACCUM   = 3'd3,
        ST_EMIT    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

endpackage

// File: rtl/yin_diff_engine_square_diff.sv
// Combinational (a - b)^2 for signed samples; one extra bit on the difference
// and two on the square so that full-scale opposite-sign inputs cannot overflow.
module yin_diff_engine_square_diff
    import yin_diff_engine_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_BITS
) (
    input  logic signed [DATA_WIDTH-1:0]   a,
    input  logic signed [DATA_WIDTH-1:0]   b,
    output logic        [2*DATA_WIDTH+1:0] sq
);

    localparam int SQ_WIDTH = 2*DATA_WIDTH + 2;

    logic signed [DATA_WIDTH:0] diff;
    logic        [DATA_WIDTH:0] mag;

    always_comb begin
        diff = {a[DATA_WIDTH-1], a} - {b[DATA_WIDTH-1], b};
        mag  = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
        sq   = SQ_WIDTH'(mag) * SQ_WIDTH'(mag);
    end

endmodule

// File: rtl/yin_diff_engine.sv
// YIN difference-function engine: sweeps tau over TAU_MIN..TAU_MAX, reading an
// external sample buffer and streaming d(tau) out over a valid/ready handshake.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | waiting for start
// FETCH_A  | present address base+j
// FETCH_B  | present address base+j+tau, capture x[j]
// ACCUM    | add (x[j] - x[j+tau])^2 into acc, advance j
// EMIT     | load result registers, hold until diff_ready
// DONE     | one-cycle done pulse
module yin_diff_engine
    import yin_diff_engine_pkg::*;
#(
    parameter int DATA_WIDTH       = DATA_WIDTH_BITS,
    parameter int ADDRESS_WIDTH    = BUFFER_SIZE_BITS,
    parameter int WINDOW_SIZE_BITS = DEF_WINDOW_SIZE_BITS,
    parameter int TAU_MIN          = DEF_TAU_MIN,
    parameter int TAU_MAX          = DEF_TAU_MAX
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        start,
    input  logic        [ADDRESS_WIDTH-1:0]             base_address,
    output logic        [ADDRESS_WIDTH-1:0]             address,
    input  logic signed [DATA_WIDTH-1:0]                data_in,
    output logic        [2*DATA_WIDTH+1+WINDOW_SIZE_BITS:0] diff_out,
    output logic        [ADDRESS_WIDTH-1:0]             tau_out,
    output logic                                        diff_valid,
    input  logic                                        diff_ready,
    output logic                                        busy,
    output logic                                        done
);

    localparam int ACC_WIDTH = 2*DATA_WIDTH + 2 + WINDOW_SIZE_BITS;
    localparam int SQ_WIDTH  = 2*DATA_WIDTH + 2;
    localparam logic [WINDOW_SIZE_BITS-1:0] J_LAST    = '1;
    localparam logic [ADDRESS_WIDTH-1:0]    TAU_FIRST = ADDRESS_WIDTH'(TAU_MIN);
    localparam logic [ADDRESS_WIDTH-1:0]    TAU_LAST  = ADDRESS_WIDTH'(TAU_MAX);

    state_t                          state;
    logic        [ADDRESS_WIDTH-1:0] base;
    logic        [ADDRESS_WIDTH-1:0] tau;
    logic        [WINDOW_SIZE_BITS-1:0] j;
    logic signed [DATA_WIDTH-1:0]    x_a;
    logic        [ACC_WIDTH-1:0]     acc;
    logic        [SQ_WIDTH-1:0]      sq;
    logic        [ADDRESS_WIDTH-1:0] j_addr;

    // x_b is taken straight from data_in during ACCUM rather than re-registered
    yin_diff_engine_square_diff #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_square_diff (
        .a (x_a),
        .b (data_in),
        .sq(sq)
    );

    assign j_addr = base + ADDRESS_WIDTH'(j);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            base       <= '0;
            tau        <= '0;
            j          <= '0;
            x_a        <= '0;
            acc        <= '0;
            address    <= '0;
            diff_out   <= '0;
            tau_out    <= '0;
            diff_valid <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        base  <= base_address;
                        tau   <= TAU_FIRST;
                        j     <= '0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        state <= ST_FETCH_A;
                    end
                end
                ST_FETCH_A: begin
                    address <= j_addr;
                    state   <= ST_FETCH_B;
                end
                ST_FETCH_B: begin
                    address <= j_addr + tau;
                    x_a     <= data_in;
                    state   <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    acc <= acc + ACC_WIDTH'(sq);
                    if (j == J_LAST) begin
                        state <= ST_EMIT;
                    end else begin
                        j     <= j + 1'b1;
                        state <= ST_FETCH_A;
                    end
                end
                // First EMIT cycle loads the result registers; handshake from the next one on
                ST_EMIT: begin
                    if (!diff_valid) begin
                        diff_valid <= 1'b1;
                        diff_out   <= acc;
                        tau_out    <= tau;
                    end else if (diff_ready) begin
                        diff_valid <= 1'b0;
                        if (tau == TAU_LAST) begin
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            tau   <= tau + 1'b1;
                            j     <= '0;
                            acc   <= '0;
                            state <= ST_FETCH_A;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
